// File: rtl/div_unit_if.sv
// Execute-stage divider bus: the pipeline side starts a divide and supplies
// forwarded operands; the divider answers with a stall request and the result.
interface div_unit_if #(
  parameter int XLEN = 32
);
  logic            StartE;
  logic [1:0]      OpE;
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;
  logic            FlushE;
  logic            BusyE;
  logic            DoneE;
  logic [XLEN-1:0] ResultE;

  // Pipeline / hazard-unit side
  modport master (
    output StartE, OpE, SrcAE, SrcBE, FlushE,
    input  BusyE, DoneE, ResultE
  );

  // Divider side
  modport slave (
    input  StartE, OpE, SrcAE, SrcBE, FlushE,
    output BusyE, DoneE, ResultE
  );
endinterface

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), radix-2 restoring, 32 iterations.
// Works on magnitudes and applies the sign fix-up when the result is registered.
module div_unit (
  input  logic       clk,
  input  logic       reset,
  div_unit_if.slave  bus
);
  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      count_q, count_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [1:0]      op_q, op_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            signed_op;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] diff;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  // State register; reset wins over every other transition
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      op_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      op_q      <= op_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  // Next-state, datapath iteration and handshake outputs
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    op_d       = op_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;

    signed_op  = ~bus.OpE[0];
    a_neg      = signed_op & bus.SrcAE[XLEN-1];
    b_neg      = signed_op & bus.SrcBE[XLEN-1];
    a_abs      = a_neg ? (~bus.SrcAE + 1'b1) : bus.SrcAE;
    b_abs      = b_neg ? (~bus.SrcBE + 1'b1) : bus.SrcBE;
    shifted    = {rem_q, quo_q[XLEN-1]};
    diff       = shifted - {2'b00, dvs_q};
    quo_fix    = '0;
    rem_fix    = '0;

    // Busy must never look at FlushE so the hazard unit has no loop through it
    bus.BusyE  = ~reset & (((state_q == S_IDLE) & bus.StartE) | (state_q == S_RUN));
    // A flush landing on the result cycle kills the instruction, so no done pulse
    bus.DoneE  = (state_q == S_DONE) & ~bus.FlushE;
    bus.ResultE = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.StartE && !bus.FlushE) begin
          op_d      = bus.OpE;
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          rem_d     = '0;
          quo_d     = a_abs;
          dvs_d     = b_abs;
          if (bus.SrcBE == '0) begin
            result_d = bus.OpE[1] ? bus.SrcAE : '1;
            state_d  = S_DONE;
          end else if (signed_op && (bus.SrcAE == 32'h8000_0000) &&
                       (bus.SrcBE == 32'hFFFF_FFFF)) begin
            result_d = bus.OpE[1] ? '0 : 32'h8000_0000;
            state_d  = S_DONE;
          end else begin
            count_d = 5'd31;
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (!diff[XLEN+1]) begin
          rem_d = diff[XLEN:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = shifted[XLEN:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        quo_fix = neg_quo_q ? (~quo_d + 1'b1) : quo_d;
        rem_fix = neg_rem_q ? (~rem_d[XLEN-1:0] + 1'b1) : rem_d[XLEN-1:0];
        if (bus.FlushE) begin
          state_d = S_IDLE;
        end else if (count_q == 5'd0) begin
          result_d = op_q[1] ? rem_fix : quo_fix;
          state_d  = S_DONE;
        end else begin
          count_d = count_q - 5'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: reference results come from SV's own signed and
// unsigned division, queued at issue and retired when DoneE pulses.
module tb_div_unit;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [31:0] expQ[$];
  logic [31:0] lastRes;

  div_unit_if bus ();

  div_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result for one operation
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic sgn;
    sgn = ~op[0];
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'd0 : 32'h8000_0000;
    if (sgn) return op[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return op[1] ? a % b : a / b;
  endfunction

  // Cycles from T to the DONE cycle
  function automatic int latency(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one divide at the start of a cycle (cycle T)
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input bit push);
    @(posedge clk);
    #1;
    bus.StartE = 1'b1;
    bus.OpE    = op;
    bus.SrcAE  = a;
    bus.SrcBE  = b;
    bus.FlushE = 1'b0;
    if (push) expQ.push_back(model(op, a, b));
  endtask

  // Follow an operation from T through its DONE cycle
  task automatic waitResult(input int lat);
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      checkOutput($sformatf("busy_c%0d", c), {31'd0, bus.BusyE}, {31'd0, (c < lat)});
      checkOutput($sformatf("done_c%0d", c), {31'd0, bus.DoneE}, {31'd0, (c == lat)});
      if (bus.DoneE) begin
        if (expQ.size() == 0) begin
          checkOutput("spurious_done", 32'd1, 32'd0);
        end else begin
          lastRes = expQ.pop_front();
          checkOutput("result", bus.ResultE, lastRes);
        end
      end
    end
  endtask

  // Retire the instruction and check the pulse ended but the result held
  task automatic finishOp();
    @(posedge clk);
    #1;
    bus.StartE = 1'b0;
    @(negedge clk);
    checkOutput("done_after", {31'd0, bus.DoneE}, 32'd0);
    checkOutput("busy_after", {31'd0, bus.BusyE}, 32'd0);
    checkOutput("result_hold", bus.ResultE, lastRes);
  endtask

  task automatic noDoneFor(input string tag, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.DoneE) seen++;
    end
    checkOutput(tag, seen, 32'd0);
  endtask

  logic [1:0]  opTab[15];
  logic [31:0] aTab[15];
  logic [31:0] bTab[15];

  initial begin
    checks     = 0;
    errors     = 0;
    lastRes    = '0;
    reset      = 1'b1;
    bus.StartE = 1'b0;
    bus.OpE    = 2'b00;
    bus.SrcAE  = '0;
    bus.SrcBE  = '0;
    bus.FlushE = 1'b0;

    opTab = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b00, 2'b10, 2'b01, 2'b11,
              2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b11, 2'b10};
    aTab  = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7,
              32'd5, 32'd5, 32'hFFFF_FFFB, 32'h8000_0000, 32'h8000_0000,
              32'hFFFF_FFFF, 32'h8000_0000, 32'hDEAD_BEEF, 32'h8765_4321};
    bTab  = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
              32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'd1, 32'd3, 32'h0001_2345, 32'hFFFF_FF10};

    $display("[TB] reset");
    repeat (2) @(posedge clk);
    #1;
    bus.StartE = 1'b1;
    @(negedge clk);
    checkOutput("reset_busy", {31'd0, bus.BusyE}, 32'd0);
    checkOutput("reset_done", {31'd0, bus.DoneE}, 32'd0);
    checkOutput("reset_result", bus.ResultE, 32'd0);
    @(posedge clk);
    #1;
    bus.StartE = 1'b0;
    reset = 1'b0;

    $display("[TB] directed divides");
    for (int i = 0; i < 15; i++) begin
      applyStimulus(opTab[i], aTab[i], bTab[i], 1'b1);
      waitResult(latency(opTab[i], aTab[i], bTab[i]));
      finishOp();
    end

    $display("[TB] random divides");
    for (int i = 0; i < 4; i++) begin
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom | 32'd1;
      applyStimulus(op, a, b, 1'b1);
      waitResult(latency(op, a, b));
      finishOp();
    end

    $display("[TB] back-to-back");
    applyStimulus(2'b01, 32'd1000, 32'd9, 1'b1);
    waitResult(33);
    applyStimulus(2'b01, 32'd12345, 32'd10, 1'b1);
    waitResult(33);
    finishOp();

    $display("[TB] reset mid-operation");
    applyStimulus(2'b01, 32'd999, 32'd4, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput("rst_run_busy", {31'd0, bus.BusyE}, 32'd1);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_forced_busy", {31'd0, bus.BusyE}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.StartE = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", {31'd0, bus.BusyE}, 32'd0);
    checkOutput("rst_done", {31'd0, bus.DoneE}, 32'd0);
    checkOutput("rst_result", bus.ResultE, 32'd0);
    noDoneFor("rst_no_done", 40);

    $display("[TB] flush mid-operation");
    applyStimulus(2'b00, 32'd500, 32'd7, 1'b0);
    for (int c = 0; c < 5; c++) @(negedge clk);
    @(posedge clk);
    #1;
    bus.FlushE = 1'b1;
    @(negedge clk);
    checkOutput("flush_busy_indep", {31'd0, bus.BusyE}, 32'd1);
    @(posedge clk);
    #1;
    bus.FlushE = 1'b0;
    bus.StartE = 1'b0;
    @(negedge clk);
    checkOutput("flush_idle_busy", {31'd0, bus.BusyE}, 32'd0);
    noDoneFor("flush_no_done", 40);

    $display("[TB] start with flush in idle");
    @(posedge clk);
    #1;
    bus.StartE = 1'b1;
    bus.FlushE = 1'b1;
    bus.OpE    = 2'b01;
    bus.SrcAE  = 32'd77;
    bus.SrcBE  = 32'd0;
    @(negedge clk);
    checkOutput("sf_busy", {31'd0, bus.BusyE}, 32'd1);
    @(posedge clk);
    #1;
    bus.StartE = 1'b0;
    bus.FlushE = 1'b0;
    @(negedge clk);
    checkOutput("sf_not_started", {31'd0, bus.BusyE}, 32'd0);
    noDoneFor("sf_no_done", 40);
    checkOutput("sf_result", bus.ResultE, 32'd0);

    checkOutput("queue_empty", expQ.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
